// File: rtl/branch_resolver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolver_pkg                                                        |
// | Shared types and constants for the stage-3 branch resolver.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package branch_resolver_pkg;

  localparam int c_xlen_def        = 32;
  localparam int c_flush_depth_def = 2;

  typedef logic [c_xlen_def-1:0] word_t;

  localparam int c_cmp_eq = 0;
  localparam int c_cmp_ne = 1;
  localparam int c_cmp_lt = 2;
  localparam int c_cmp_ge = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolver_flush_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolver_flush_sequencer                                            |
// | Redirect/flush state machine with a down-counter of remaining flush cycles.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_resolver_flush_sequencer
  import branch_resolver_pkg::*;
#(
  parameter int FLUSH_DEPTH = c_flush_depth_def
) (
  input  logic   clock_i,
  input  logic   reset_i,
  input  logic   start_i,
  input  logic   stall_i,
  output logic   redirect_o,
  output logic   flush_front_o,
  output state_t state_o
);

  // Counter holds the FLUSH cycles still owed after the REDIRECT cycle.
  localparam logic [2:0] c_cnt_init = 3'(FLUSH_DEPTH - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stall_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_REDIRECT;
            cnt_d   = c_cnt_init;
          end
        end
        ST_REDIRECT: state_d = (cnt_q == 3'd0) ? ST_IDLE : ST_FLUSH;
        ST_FLUSH: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign redirect_o    = (state_q == ST_REDIRECT);
  assign flush_front_o = (state_q != ST_IDLE);
  assign state_o       = state_q;

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolver                                                            |
// | Resolves stage-3 branches/jumps, issues registered redirects and flushes.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int XLEN        = c_xlen_def,
  parameter int FLUSH_DEPTH = c_flush_depth_def,
  parameter int CNT_W       = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             valid_i,
  input  logic             is_branch_i,
  input  logic             is_jump_i,
  input  logic             is_jalr_i,
  input  logic [1:0]       cond_sel_i,
  input  logic [3:0]       compare_async_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  jump_target_i,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_front_o,
  output logic             misalign_fault_o,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] taken_count_o
);

  state_t          w_state;
  logic            w_resolve, w_taken, w_aligned, w_start, w_fault, w_count_branch;
  logic [XLEN-1:0] w_target;

  logic             misalign_q, misalign_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  // Wrong-path instructions arriving during REDIRECT/FLUSH are never resolved.
  assign w_resolve      = (w_state == ST_IDLE) & valid_i & ~stall_i;
  assign w_taken        = is_jump_i | (is_branch_i & compare_async_i[cond_sel_i]);
  assign w_target       = is_jalr_i ? (jump_target_i & ~XLEN'(1)) : (pc_i + imm_i);
  assign w_aligned      = (w_target[1:0] == 2'b00);
  assign w_start        = w_resolve & w_taken & w_aligned;
  assign w_fault        = w_resolve & w_taken & ~w_aligned;
  assign w_count_branch = w_resolve & is_branch_i & ~is_jump_i;

  branch_resolver_flush_sequencer #(
    .FLUSH_DEPTH (FLUSH_DEPTH)
  ) u_seq (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .start_i       (w_start),
    .stall_i       (stall_i),
    .redirect_o    (redirect_o),
    .flush_front_o (flush_front_o),
    .state_o       (w_state)
  );

  always_comb begin
    misalign_d     = misalign_q;
    redirect_pc_d  = redirect_pc_q;
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    if (!stall_i) begin
      misalign_d = w_fault;
      if (w_start) begin
        redirect_pc_d = w_target;
        taken_count_d = taken_count_q + CNT_W'(1);
      end
      if (w_count_branch) branch_count_d = branch_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      misalign_q     <= 1'b0;
      redirect_pc_q  <= '0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      misalign_q     <= misalign_d;
      redirect_pc_q  <= redirect_pc_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign misalign_fault_o = misalign_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign branch_count_o   = branch_count_q;
  assign taken_count_o    = taken_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_resolver                                                         |
// | Directed scoreboard bench: stimulus queues expectations, monitor checks.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_branch_resolver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, valid = 1'b0, is_branch = 1'b0, is_jump = 1'b0, is_jalr = 1'b0;
  logic [1:0]  cond_sel = 2'd0;
  logic [3:0]  compare = 4'd0;
  logic [31:0] pc = '0, imm = '0, jtgt = '0;
  logic        redirect, flush_front, misalign_fault;
  logic [31:0] redirect_pc, branch_count, taken_count;

  always #5 clock = ~clock;

  branch_resolver #(.XLEN(32), .FLUSH_DEPTH(2), .CNT_W(32)) dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .stall_i          (stall),
    .valid_i          (valid),
    .is_branch_i      (is_branch),
    .is_jump_i        (is_jump),
    .is_jalr_i        (is_jalr),
    .cond_sel_i       (cond_sel),
    .compare_async_i  (compare),
    .pc_i             (pc),
    .imm_i            (imm),
    .jump_target_i    (jtgt),
    .redirect_o       (redirect),
    .redirect_pc_o    (redirect_pc),
    .flush_front_o    (flush_front),
    .misalign_fault_o (misalign_fault),
    .branch_count_o   (branch_count),
    .taken_count_o    (taken_count)
  );

  typedef struct packed {
    logic        red;
    logic [31:0] rpc;
    logic        fl;
    logic        mis;
    logic [31:0] bc;
    logic [31:0] tc;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic obs_t o(input logic red, input logic [31:0] rpc, input logic fl,
                             input logic mis, input logic [31:0] bc, input logic [31:0] tc);
    return {red, rpc, fl, mis, bc, tc};
  endfunction

  function automatic obs_t sample();
    return {redirect, redirect_pc, flush_front, misalign_fault, branch_count, taken_count};
  endfunction

  task automatic check(input string nm, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got red=%0b pc=%h fl=%0b mis=%0b bc=%0d tc=%0d, want red=%0b pc=%h fl=%0b mis=%0b bc=%0d tc=%0d",
               nm, a.red, a.rpc, a.fl, a.mis, a.bc, a.tc, e.red, e.rpc, e.fl, e.mis, e.bc, e.tc);
    end
  endtask

  // Inputs change at negedge; the expectation describes outputs after the next posedge.
  task automatic step(input string nm, input logic v, input logic br, input logic jp,
                      input logic jr, input logic [1:0] sel, input logic [3:0] cmp,
                      input logic [31:0] p, input logic [31:0] im, input logic [31:0] jt,
                      input logic st, input obs_t e);
    @(negedge clock);
    valid = v; is_branch = br; is_jump = jp; is_jalr = jr;
    cond_sel = sel; compare = cmp; pc = p; imm = im; jtgt = jt; stall = st;
    q.push_back('{nm, e});
  endtask

  task automatic nop(input string nm, input obs_t e);
    step(nm, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, e);
  endtask

  initial begin
    ent_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, sample(), e.v);
      end
    end
  end

  initial begin
    nop("reset0", o(0, 32'h0, 0, 0, 0, 0));
    nop("reset1", o(0, 32'h0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b0;

    step("beq_taken", 1, 1, 0, 0, 2'd0, 4'b0001, 32'h100, 32'h20, 32'h0, 0, o(1, 32'h120, 1, 0, 1, 1));
    nop("beq_flush", o(0, 32'h120, 1, 0, 1, 1));
    nop("beq_idle",  o(0, 32'h120, 0, 0, 1, 1));

    step("bne_not_taken", 1, 1, 0, 0, 2'd1, 4'b0001, 32'h200, 32'h40, 32'h0, 0, o(0, 32'h120, 0, 0, 2, 1));

    step("jalr_misalign", 1, 0, 1, 1, 2'd0, 4'b0000, 32'h0, 32'h0, 32'h1003, 0, o(0, 32'h120, 0, 1, 2, 1));
    nop("misalign_drop", o(0, 32'h120, 0, 0, 2, 1));

    step("stalled_idle_br", 1, 1, 0, 0, 2'd0, 4'b0001, 32'h600, 32'h4, 32'h0, 1, o(0, 32'h120, 0, 0, 2, 1));

    step("blt_taken", 1, 1, 0, 0, 2'd2, 4'b0100, 32'h300, 32'h40, 32'h0, 0, o(1, 32'h340, 1, 0, 3, 2));
    step("redir_stall1", 1, 1, 0, 0, 2'd0, 4'b0001, 32'h700, 32'h8, 32'h0, 1, o(1, 32'h340, 1, 0, 3, 2));
    step("redir_stall2", 1, 1, 0, 0, 2'd0, 4'b0001, 32'h700, 32'h8, 32'h0, 1, o(1, 32'h340, 1, 0, 3, 2));
    step("redir_release", 1, 1, 0, 0, 2'd0, 4'b0001, 32'h700, 32'h8, 32'h0, 0, o(0, 32'h340, 1, 0, 3, 2));
    step("flush_ignores", 1, 1, 0, 0, 2'd0, 4'b0001, 32'h700, 32'h8, 32'h0, 0, o(0, 32'h340, 0, 0, 3, 2));

    step("jal_wrap_prio", 1, 1, 1, 0, 2'd0, 4'b0000, 32'hFFFF_FFF0, 32'h20, 32'h0, 0, o(1, 32'h10, 1, 0, 3, 3));
    nop("jal_flush", o(0, 32'h10, 1, 0, 3, 3));
    nop("jal_idle",  o(0, 32'h10, 0, 0, 3, 3));

    step("bge_taken", 1, 1, 0, 0, 2'd3, 4'b1000, 32'h400, 32'h8, 32'h0, 0, o(1, 32'h408, 1, 0, 4, 4));
    nop("bge_flush", o(0, 32'h408, 1, 0, 4, 4));
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", sample(), o(0, 32'h0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b0;

    step("post_rst_beq", 1, 1, 0, 0, 2'd0, 4'b0001, 32'h500, 32'h10, 32'h0, 0, o(1, 32'h510, 1, 0, 1, 1));
    nop("post_rst_flush", o(0, 32'h510, 1, 0, 1, 1));
    nop("post_rst_idle",  o(0, 32'h510, 0, 0, 1, 1));

    repeat (4) @(posedge clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
